// File: rtl/cfg_loader.sv
// Serial configuration loader: hunts for a sync header, shifts in 3*NFIELDS select bits
// and commits them atomically. Define CFG_CHECKSUM_EN to add the trailing 8-bit checksum check.
module cfg_loader #(
  parameter int         NFIELDS = 25,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_din,
  input  logic                 cfg_valid,
  input  logic                 cfg_abort,
  output logic [3*NFIELDS-1:0] cfg_word,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 busy
);

  localparam int W  = 3 * NFIELDS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {HUNT, LOAD, CSUM, RESULT} state_t;

  state_t        state, state_next;
  logic [7:0]    hdr, hdr_next;
  logic [W-1:0]  shadow, shadow_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [W-1:0]  word_next;
  logic          done_next;

`ifdef CFG_CHECKSUM_EN
  logic [7:0] sum, sum_next;
  logic [7:0] csum, csum_next;
  logic [1:0] phase, phase_next;
  logic       err_next;
`else
  assign cfg_err = 1'b0;
`endif

  assign busy = (state != HUNT);

  always_comb begin
    state_next  = state;
    hdr_next    = hdr;
    shadow_next = shadow;
    cnt_next    = cnt;
    word_next   = cfg_word;
    done_next   = 1'b0;
`ifdef CFG_CHECKSUM_EN
    sum_next    = sum;
    csum_next   = csum;
    phase_next  = phase;
    err_next    = 1'b0;
`endif
    if (cfg_abort) begin
      state_next = HUNT;
      hdr_next   = '0;
      cnt_next   = '0;
`ifdef CFG_CHECKSUM_EN
      phase_next = '0;
      sum_next   = '0;
`endif
    end else begin
      case (state)
        HUNT: begin
          if (cfg_valid) begin
            hdr_next = {hdr[6:0], cfg_din};
            if ({hdr[6:0], cfg_din} == SYNC) begin
              state_next = LOAD;
              cnt_next   = '0;
`ifdef CFG_CHECKSUM_EN
              sum_next   = '0;
              phase_next = '0;
`endif
            end
          end
        end
        LOAD: begin
          if (cfg_valid) begin
            // Right shift: after W bits the first bit received lands in bit 0.
            shadow_next = {cfg_din, shadow[W-1:1]};
`ifdef CFG_CHECKSUM_EN
            // On a field's third bit its two earlier bits sit at the top of the shadow.
            if (phase == 2'd2) begin
              sum_next   = sum + {5'd0, cfg_din, shadow[W-1], shadow[W-2]};
              phase_next = '0;
            end else begin
              phase_next = phase + 2'd1;
            end
`endif
            if (cnt == CW'(W - 1)) begin
              cnt_next = '0;
`ifdef CFG_CHECKSUM_EN
              state_next = CSUM;
`else
              state_next = RESULT;
`endif
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
`ifdef CFG_CHECKSUM_EN
        CSUM: begin
          if (cfg_valid) begin
            csum_next = {csum[6:0], cfg_din};
            if (cnt == CW'(7)) begin
              cnt_next   = '0;
              state_next = RESULT;
            end else begin
              cnt_next = cnt + 1'b1;
            end
          end
        end
`endif
        RESULT: begin
          // Lasts one cycle regardless of cfg_valid; any bit offered here is dropped.
          state_next = HUNT;
          hdr_next   = '0;
`ifdef CFG_CHECKSUM_EN
          if (csum == sum) begin
            word_next = shadow;
            done_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
`else
          word_next = shadow;
          done_next = 1'b1;
`endif
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      hdr      <= '0;
      shadow   <= '0;
      cnt      <= '0;
      cfg_word <= '0;
      cfg_done <= 1'b0;
`ifdef CFG_CHECKSUM_EN
      sum      <= '0;
      csum     <= '0;
      phase    <= '0;
      cfg_err  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      hdr      <= hdr_next;
      shadow   <= shadow_next;
      cnt      <= cnt_next;
      cfg_word <= word_next;
      cfg_done <= done_next;
`ifdef CFG_CHECKSUM_EN
      sum      <= sum_next;
      csum     <= csum_next;
      phase    <= phase_next;
      cfg_err  <= err_next;
`endif
    end
  end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 SHALL have parameter NFIELDS, default 25, giving the number of 3-bit select fields per frame.
REQ-002 SHALL have parameter SYNC, default 8'hA5, giving the frame header pattern.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_din  input  1  serial bitstream data.
REQ-006 SHALL have port cfg_valid  input  1  cfg_din is consumed on each clk edge where this is high.
REQ-007 SHALL have port cfg_abort  input  1  discards any frame in progress.
REQ-008 SHALL have port cfg_word  output  3*NFIELDS  committed selects.
- Field i occupies bits [3i+2:3i].
- Field order: out1,in1,ts1, ..., out6,in6,ts6, then A,B,C,D,K,X,Y.
REQ-009 SHALL have port cfg_done  output  1  one-cycle pulse on frame commit.
REQ-010 SHALL have port cfg_err  output  1  one-cycle pulse on checksum mismatch.
REQ-011 SHALL have port busy  output  1  high in every state except HUNT.

Function
REQ-012 SHALL implement states HUNT, LOAD, CSUM and RESULT.
REQ-013 In HUNT: SHALL shift each valid bit into an 8-bit header register, MSB first, and enter LOAD on the edge where the register contents equal SYNC.
REQ-014 In LOAD: SHALL shift 3*NFIELDS valid bits into a shadow register, LSB of field 0 first, using a bit counter from 0 to 3*NFIELDS-1.
REQ-015 In LOAD: SHALL accumulate an 8-bit modulo-256 sum of the completed 3-bit field values.
REQ-016 On the last field bit, LOAD SHALL go to CSUM.
REQ-017 In CSUM: SHALL receive 8 valid checksum bits, MSB first, then go to RESULT.
REQ-018 In RESULT (one cycle), on a checksum match SHALL load cfg_word from the shadow register and pulse cfg_done.
- cfg_word changes on the edge after the final checksum bit is sampled.
- cfg_done is high for exactly the cycle after that edge.
REQ-019 In RESULT, on a mismatch SHALL leave cfg_word unchanged and pulse cfg_err with the same timing as cfg_done.
REQ-020 RESULT SHALL always return to HUNT with the header register cleared.
REQ-021 Cycles with cfg_valid low SHALL stall the current state; counters and shift registers hold.
REQ-022 cfg_abort high SHALL force HUNT on the next edge, clear the counters and header register, and leave cfg_word unchanged.
- cfg_abort takes priority over cfg_valid and over RESULT.
- If cfg_abort is high in RESULT, no cfg_done or cfg_err pulse is produced.
REQ-023 cfg_done and cfg_err SHALL never both be high.
REQ-024 cfg_word SHALL change only on a commit.
REQ-025 A bit arriving in RESULT SHALL be ignored; the header hunt restarts from the following cycle.
REQ-026 The bit counter SHALL be sized for the value 3*NFIELDS and SHALL NOT wrap within a frame.

Reset
REQ-027 While rst_n is low, SHALL immediately reset:
- state to HUNT;
- cfg_word, shadow register, counters, sum and header register to 0;
- cfg_done, cfg_err and busy to 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; the first edge after release begins a new header hunt.

Configuration
REQ-029 With CFG_CHECKSUM_EN defined: SHALL have the CSUM state and the behaviour of REQ-015, REQ-017 and REQ-019.
REQ-030 Without CFG_CHECKSUM_EN:
- LOAD SHALL go directly to RESULT.
- Every complete frame SHALL commit and pulse cfg_done.
- cfg_err SHALL be tied to 0.
- No sum logic SHALL exist.

Verification
REQ-031 Reset, then header A5 followed by all fields = 3'd1 and checksum 8'd25 -> cfg_word = {25{3'b001}}; cfg_done high one cycle; busy low afterwards.
REQ-032 Same frame with checksum 8'd26 -> cfg_err pulse; cfg_word stays 0; a following good frame commits.
REQ-033 Noise bits 1,0,1 before the header, with cfg_valid low for 5 random cycles mid-frame -> commit identical to REQ-031, delayed by the stall cycles.
REQ-034 cfg_abort at field bit 40, then a full good frame with all fields = 3'd7 and checksum 8'd175 -> no pulse on abort; single cfg_done; cfg_word = all ones.
REQ-035 rst_n low at checksum bit 3 -> outputs zero asynchronously; no pulse; a full frame after release commits.
REQ-036 Build without CFG_CHECKSUM_EN, header plus 75 bits only -> cfg_done one cycle after the last field bit; cfg_err always 0.
